// File: rtl/data_ram_if.sv
// Request/response bundle between a requester and the byte-addressed data RAM.
// Latency: not applicable (wires only).
// Backpressure: the slave drives ready; the master only treats req as taken when ready=1.
interface data_ram_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, addr, wdata,
    input  ready, ack, err, rdata
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output ready, ack, err, rdata
  );
endinterface

// File: rtl/data_ram.sv
// Byte-addressed little-endian RAM with byte/half/word access and self-clearing after reset.
// Latency: response (ack/err/rdata) registered, exactly one cycle after acceptance.
// Backpressure: ready=0 while clearing after reset; in IDLE a request is accepted every cycle.
module data_ram #(
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  data_ram_if.slave  bus
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned AW    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]   clr_base;

  logic [7:0]      mem [DEPTH_BYTES];

  logic            ready;
  logic            accept;
  logic [2:0]      nbytes;
  logic [32:0]     last_byte;
  logic            req_err;
  logic [AW-1:0]   idx [4];
  logic [31:0]     load_dat;

  logic            ack_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  assign ready    = (state_q == IDLE);
  assign accept   = bus.req && ready;
  assign clr_base = AW'({clr_cnt_q, 2'b00});

  // Decode access width, range check in 33 bits so high addresses cannot wrap, and gather load bytes.
  always_comb begin
    nbytes   = 3'd0;
    load_dat = 32'd0;
    case (bus.size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    last_byte = {1'b0, bus.addr} + {30'd0, nbytes} - 33'd1;
    req_err   = (bus.size == 2'b11) || (last_byte > 33'(DEPTH_BYTES - 1));
    for (int k = 0; k < 4; k++) begin
      idx[k] = bus.addr[AW-1:0] + AW'(k);
    end
    if (!req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(nbytes)) begin
          load_dat[8*k +: 8] = mem[idx[k]];
        end
      end
    end
  end

  // Next-state: walk the clear counter through every word, then sit in IDLE until reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == CW'(WORDS - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_cnt_d = clr_cnt_q;
      end
    endcase
  end

  // State and clear counter registers; reset always restarts clearing from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage: zero one word per cycle while clearing, otherwise commit accepted in-range stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        for (int k = 0; k < 4; k++) begin
          mem[clr_base + AW'(k)] <= 8'd0;
        end
      end else if (accept && bus.we && !req_err) begin
        for (int k = 0; k < 4; k++) begin
          if (k < int'(nbytes)) begin
            mem[idx[k]] <= bus.wdata[8*k +: 8];
          end
        end
      end
    end
  end

  // Response registers: one-cycle ack per acceptance; err/rdata forced to zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q   <= accept;
      err_q   <= accept && req_err;
      rdata_q <= (accept && !bus.we && !req_err) ? load_dat : 32'd0;
    end
  end

  assign bus.ready = ready;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule
